// File: rtl/if_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : PC register and instruction-fetch sequencer. Holds the
//               architectural fetch PC, drives a one-outstanding-request
//               instruction-memory handshake and presents fetched words to ID
//               with a valid/ready handshake. Redirects take effect after the
//               current fetch (MIPS delay slot). Flushes cancel it.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1   clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   redirect     in   1   branch/jump taken, npc valid
//   npc          in   32  redirect target (bits [1:0] ignored)
//   flush        in   1   exception flush, cancels in-flight/held fetch
//   flush_pc     in   32  handler address (bits [1:0] ignored)
//   imem_req     out  1   fetch request
//   imem_addr    out  32  fetch address, word aligned
//   imem_gnt     in   1   request accepted this cycle
//   imem_rvalid  in   1   read data valid, one per granted request
//   imem_rdata   in   32  instruction word
//   if_valid     out  1   if_pc/if_instr valid toward ID
//   if_ready     in   1   ID accepts this cycle
//   if_pc        out  32  PC of the presented instruction
//   if_instr     out  32  presented instruction word
// ============================================================================
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] npc,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_req_pc;
    logic [31:0] r_redir_pc;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_instr;
    logic        r_drop;
    logic        r_pend_redir;
    logic        r_imem_req;
    logic        r_if_valid;

    logic        w_gnt;
    logic [31:0] w_npc_al;
    logic [31:0] w_flush_al;
    logic [31:0] w_next_pc;
    logic        w_unused;

    // Low address bits of the targets are dropped without raising anything.
    assign w_npc_al   = {npc[31:2], 2'b00};
    assign w_flush_al = {flush_pc[31:2], 2'b00};
    assign w_unused   = ^{npc[1:0], flush_pc[1:0]};

    // A grant only counts while a request is actually on the bus; this keeps
    // the first cycle after reset (state REQ, request still low) harmless.
    assign w_gnt = imem_gnt & r_imem_req;

    // Address of the next fetch once the held instruction is consumed. A
    // pending redirect replaces the sequential successor; the adder wraps.
    assign w_next_pc = r_pend_redir ? r_redir_pc : (r_if_pc + PC_STEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_REQ;
            r_fetch_pc   <= RESET_PC;
            r_req_pc     <= RESET_PC;
            r_redir_pc   <= RESET_PC;
            r_if_pc      <= RESET_PC;
            r_if_instr   <= 32'd0;
            r_drop       <= 1'b0;
            r_pend_redir <= 1'b0;
            r_imem_req   <= 1'b0;
            r_if_valid   <= 1'b0;
        end else begin
            case (r_state)
                S_REQ: begin
                    r_imem_req <= 1'b1;
                    if (w_gnt) begin
                        // A flush in the grant cycle still lets the request
                        // go out, but its data must be thrown away.
                        r_state    <= S_WAIT;
                        r_imem_req <= 1'b0;
                        r_req_pc   <= r_fetch_pc;
                        r_drop     <= flush;
                    end
                    // Without a grant the request is abandoned, so the
                    // address may change under a flush.
                    if (flush) begin
                        r_fetch_pc <= w_flush_al;
                    end
                end

                S_WAIT: begin
                    if (flush) begin
                        r_fetch_pc <= w_flush_al;
                    end
                    if (imem_rvalid) begin
                        r_drop <= 1'b0;
                        if (r_drop || flush) begin
                            r_state    <= S_REQ;
                            r_imem_req <= 1'b1;
                        end else begin
                            r_if_instr <= imem_rdata;
                            r_if_pc    <= r_req_pc;
                            r_state    <= S_HOLD;
                            r_if_valid <= 1'b1;
                        end
                    end else if (flush) begin
                        r_drop <= 1'b1;
                    end
                end

                S_HOLD: begin
                    if (flush) begin
                        // Held word is discarded even if ID is ready now.
                        r_fetch_pc <= w_flush_al;
                        r_state    <= S_REQ;
                        r_if_valid <= 1'b0;
                        r_imem_req <= 1'b1;
                    end else if (if_ready) begin
                        r_fetch_pc   <= w_next_pc;
                        r_pend_redir <= 1'b0;
                        r_state      <= S_REQ;
                        r_if_valid   <= 1'b0;
                        r_imem_req   <= 1'b1;
                    end
                end

                default: begin
                    r_state    <= S_REQ;
                    r_if_valid <= 1'b0;
                    r_imem_req <= 1'b1;
                end
            endcase

            // Redirect bookkeeping sits after the state update so that a
            // redirect arriving in the consuming cycle becomes the new pending
            // target instead of being cleared with the consumed one.
            if (flush) begin
                r_pend_redir <= 1'b0;
            end else if (redirect) begin
                r_pend_redir <= 1'b1;
                r_redir_pc   <= w_npc_al;
            end
        end
    end

    assign imem_req  = r_imem_req;
    assign imem_addr = r_fetch_pc;
    assign if_valid  = r_if_valid;
    assign if_pc     = r_if_pc;
    assign if_instr  = r_if_instr;

    // Structural invariants of the sequencer.
    a_req_in_req_state : assert property (@(posedge clk) disable iff (!rst_n)
        r_imem_req |-> (r_state == S_REQ));
    a_valid_is_hold : assert property (@(posedge clk) disable iff (!rst_n)
        r_if_valid == (r_state == S_HOLD));
    a_addr_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (r_imem_req && !imem_gnt && !flush) |=> (r_fetch_pc == $past(r_fetch_pc)));

endmodule
`default_nettype wire
